id_ex_stage: RTL and testbench

Decode-to-execute pipeline register with an integrated load-use interlock. It captures decoded operands, register addresses, immediate, PC and control from ID, and presents them to EX. Its ex_read_reg1/ex_read_reg2 feed the EX operand forwarding muxes as the "no-forward" input, and its ex_rs1/ex_rs2 feed the forwarding unit. It raises a stall to PC/IF-ID when a load in EX is followed by a dependent instruction, inserts a bubble, and counts stall cycles.

---
 rtl/id_ex_stage.sv | 113 +++++++++++
 tb/tb_id_ex_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock and a saturating counter of
// bubble cycles inserted by that interlock.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_read_reg1,
    input  logic [XLEN-1:0]   id_read_reg2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              hold,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_read_reg1,
    output logic [XLEN-1:0]   ex_read_reg2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              load_use_stall,
    output logic [31:0]       stall_count
);

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   read_reg1;
        logic [XLEN-1:0]   read_reg2;
        logic [XLEN-1:0]   imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              mem_read;
        logic              reg_write;
        logic [CTRL_W-1:0] ctrl;
    } ex_t;

    ex_t         ex_q;
    ex_t         id_pkt;
    logic        src_hit;
    logic [31:0] count_q;

    // An invalid ID slot still carries its data, but must never write or load.
    always_comb begin
        id_pkt           = '0;
        id_pkt.valid     = id_valid;
        id_pkt.pc        = id_pc;
        id_pkt.read_reg1 = id_read_reg1;
        id_pkt.read_reg2 = id_read_reg2;
        id_pkt.imm       = id_imm;
        id_pkt.rs1       = id_rs1;
        id_pkt.rs2       = id_rs2;
        id_pkt.rd        = id_rd;
        id_pkt.mem_read  = id_valid & id_mem_read;
        id_pkt.reg_write = id_valid & id_reg_write;
        id_pkt.ctrl      = id_valid ? id_ctrl : '0;
    end

    always_comb begin
        src_hit = (id_uses_rs1 && (id_rs1 == ex_q.rd)) ||
                  (id_uses_rs2 && (id_rs2 == ex_q.rd));
        load_use_stall = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                         id_valid && src_hit && !flush && !hold;
    end

    // A bubble zeroes the whole slot; once a bubble sits in EX the stall
    // condition drops by itself, releasing the held ID instruction.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so ordering inside this block is irrelevant.
        if (rst) begin
            ex_q    <= '0;
            count_q <= '0;
        end else if (!hold) begin
            if (flush || load_use_stall) begin
                ex_q <= '0;
                if (load_use_stall && (count_q != 32'hFFFF_FFFF))
                    count_q <= count_q + 32'd1;
            end else begin
                ex_q <= id_pkt;
            end
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_pc        = ex_q.pc;
    assign ex_read_reg1 = ex_q.read_reg1;
    assign ex_read_reg2 = ex_q.read_reg2;
    assign ex_imm       = ex_q.imm;
    assign ex_rs1       = ex_q.rs1;
    assign ex_rs2       = ex_q.rs2;
    assign ex_rd        = ex_q.rd;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_ctrl      = ex_q.ctrl;
    assign stall_count  = count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a table of per-cycle vectors carrying state
// from one row to the next, plus hand sequences for reset, hold and reset-in-stall.
module tb_id_ex_stage;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc, id_read_reg1, id_read_reg2, id_imm;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic              id_uses_rs1, id_uses_rs2, id_mem_read, id_reg_write;
    logic [CTRL_W-1:0] id_ctrl;
    logic              flush, hold;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc, ex_read_reg1, ex_read_reg2, ex_imm;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic              ex_mem_read, ex_reg_write;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              load_use_stall;
    logic [31:0]       stall_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_read_reg1(id_read_reg1), .id_read_reg2(id_read_reg2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .id_ctrl(id_ctrl),
        .flush(flush), .hold(hold),
        .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_read_reg1(ex_read_reg1), .ex_read_reg2(ex_read_reg2), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_ctrl(ex_ctrl),
        .load_use_stall(load_use_stall), .stall_count(stall_count)
    );

    typedef struct {
        logic        flush;
        logic        valid;
        logic [31:0] pc, r1;
        logic [4:0]  rd, rs1, rs2;
        logic        u1, u2, mr, rw;
        logic [7:0]  ctrl;
        logic        e_stall;
        logic        e_valid;
        logic [31:0] e_pc, e_r1;
        logic [4:0]  e_rd;
        logic        e_mr, e_rw;
        logic [7:0]  e_ctrl;
        logic [31:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(
        input logic fl, input logic v, input logic [31:0] pc, input logic [31:0] r1,
        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic u1, input logic u2, input logic mr, input logic rw, input logic [7:0] ctrl,
        input logic es, input logic ev, input logic [31:0] epc, input logic [31:0] er1,
        input logic [4:0] erd, input logic emr, input logic erw, input logic [7:0] ectrl,
        input logic [31:0] ecnt);
        vec_t t;
        t.flush = fl;  t.valid = v;  t.pc = pc;  t.r1 = r1;
        t.rd = rd;  t.rs1 = rs1;  t.rs2 = rs2;
        t.u1 = u1;  t.u2 = u2;  t.mr = mr;  t.rw = rw;  t.ctrl = ctrl;
        t.e_stall = es;  t.e_valid = ev;  t.e_pc = epc;  t.e_r1 = er1;
        t.e_rd = erd;  t.e_mr = emr;  t.e_rw = erw;  t.e_ctrl = ectrl;  t.e_cnt = ecnt;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] r1,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic mr, input logic rw,
                         input logic [7:0] ctrl);
        id_valid     = v;
        id_pc        = pc;
        id_read_reg1 = r1;
        id_read_reg2 = r1 ^ 32'h0F0F_0000;
        id_imm       = pc + 32'd4;
        id_rd        = rd;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_uses_rs1  = u1;
        id_uses_rs2  = u2;
        id_mem_read  = mr;
        id_reg_write = rw;
        id_ctrl      = ctrl;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ex_valid"}, 32'(ex_valid), 0);
        check({tag, " ex_pc"}, ex_pc, 0);
        check({tag, " ex_read_reg1"}, ex_read_reg1, 0);
        check({tag, " ex_read_reg2"}, ex_read_reg2, 0);
        check({tag, " ex_imm"}, ex_imm, 0);
        check({tag, " ex_rs1"}, 32'(ex_rs1), 0);
        check({tag, " ex_rs2"}, 32'(ex_rs2), 0);
        check({tag, " ex_rd"}, 32'(ex_rd), 0);
        check({tag, " ex_mem_read"}, 32'(ex_mem_read), 0);
        check({tag, " ex_reg_write"}, 32'(ex_reg_write), 0);
        check({tag, " ex_ctrl"}, 32'(ex_ctrl), 0);
        check({tag, " stall_count"}, stall_count, 0);
        check({tag, " load_use_stall"}, 32'(load_use_stall), 0);
    endtask

    vec_t vecs[16];

    initial begin
        // Table rows: flush valid pc r1 rd rs1 rs2 u1 u2 mr rw ctrl |
        //             stall(pre-edge) valid pc r1 rd mr rw ctrl count (post-edge)
        vecs[0]  = mk(0,1,32'h100,32'hDEADBEEF,7,5,6,1,0,0,1,8'h3C, 0,1,32'h100,32'hDEADBEEF,7,0,1,8'h3C,0);
        vecs[1]  = mk(0,1,32'h104,32'h1000,3,2,0,1,0,1,1,8'h11,     0,1,32'h104,32'h1000,3,1,1,8'h11,0);
        vecs[2]  = mk(0,1,32'h108,32'h2,8,3,4,1,1,0,1,8'h22,        1,0,32'h0,32'h0,0,0,0,8'h00,1);
        vecs[3]  = mk(0,1,32'h108,32'h2,8,3,4,1,1,0,1,8'h22,        0,1,32'h108,32'h2,8,0,1,8'h22,1);
        vecs[4]  = mk(0,1,32'h10C,32'h30,0,1,0,1,0,1,1,8'h11,       0,1,32'h10C,32'h30,0,1,1,8'h11,1);
        vecs[5]  = mk(0,1,32'h110,32'h40,5,0,0,1,1,0,1,8'h22,       0,1,32'h110,32'h40,5,0,1,8'h22,1);
        vecs[6]  = mk(0,1,32'h114,32'h50,4,1,0,1,0,1,1,8'h11,       0,1,32'h114,32'h50,4,1,1,8'h11,1);
        vecs[7]  = mk(0,1,32'h118,32'h60,9,6,4,1,0,0,1,8'h22,       0,1,32'h118,32'h60,9,0,1,8'h22,1);
        vecs[8]  = mk(0,1,32'h11C,32'h70,10,1,0,1,0,1,1,8'h11,      0,1,32'h11C,32'h70,10,1,1,8'h11,1);
        vecs[9]  = mk(1,1,32'h120,32'h80,11,10,0,1,0,0,1,8'h22,     0,0,32'h0,32'h0,0,0,0,8'h00,1);
        vecs[10] = mk(0,0,32'h124,32'h90,12,1,0,1,0,1,1,8'hFF,      0,0,32'h124,32'h90,12,0,0,8'h00,1);
        vecs[11] = mk(0,1,32'h128,32'hA0,3,1,0,1,0,1,1,8'h11,       0,1,32'h128,32'hA0,3,1,1,8'h11,1);
        vecs[12] = mk(0,1,32'h12C,32'hB0,3,3,0,1,0,1,1,8'h11,       1,0,32'h0,32'h0,0,0,0,8'h00,2);
        vecs[13] = mk(0,1,32'h12C,32'hB0,3,3,0,1,0,1,1,8'h11,       0,1,32'h12C,32'hB0,3,1,1,8'h11,2);
        vecs[14] = mk(0,1,32'h130,32'hC0,13,1,3,0,1,0,1,8'h22,      1,0,32'h0,32'h0,0,0,0,8'h00,3);
        vecs[15] = mk(0,1,32'h130,32'hC0,13,1,3,0,1,0,1,8'h22,      0,1,32'h130,32'hC0,13,0,1,8'h22,3);

        // Reset for two cycles with busy ID inputs.
        rst = 1'b1;  flush = 1'b0;  hold = 1'b0;
        drive(1, 32'h44, 32'h1234, 9, 9, 2, 1, 1, 1, 1, 8'hAA);
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst   = 1'b0;
            flush = vecs[i].flush;
            drive(vecs[i].valid, vecs[i].pc, vecs[i].r1, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].u1, vecs[i].u2, vecs[i].mr, vecs[i].rw, vecs[i].ctrl);
            #1;
            check($sformatf("v%0d load_use_stall", i), 32'(load_use_stall), 32'(vecs[i].e_stall));
            @(posedge clk);
            #1;
            check($sformatf("v%0d ex_valid", i), 32'(ex_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d ex_pc", i), ex_pc, vecs[i].e_pc);
            check($sformatf("v%0d ex_read_reg1", i), ex_read_reg1, vecs[i].e_r1);
            check($sformatf("v%0d ex_rd", i), 32'(ex_rd), 32'(vecs[i].e_rd));
            check($sformatf("v%0d ex_mem_read", i), 32'(ex_mem_read), 32'(vecs[i].e_mr));
            check($sformatf("v%0d ex_reg_write", i), 32'(ex_reg_write), 32'(vecs[i].e_rw));
            check($sformatf("v%0d ex_ctrl", i), 32'(ex_ctrl), 32'(vecs[i].e_ctrl));
            check($sformatf("v%0d stall_count", i), stall_count, vecs[i].e_cnt);
        end

        // Load rd=14 into EX, checking the fields the table does not cover.
        @(negedge clk);
        flush = 1'b0;
        drive(1, 32'h134, 32'h0000_00D0, 14, 2, 17, 1, 1, 1, 1, 8'h5A);
        @(posedge clk);
        #1;
        check("load ex_read_reg2", ex_read_reg2, 32'h0F0F_00D0);
        check("load ex_imm", ex_imm, 32'h138);
        check("load ex_rs1", 32'(ex_rs1), 2);
        check("load ex_rs2", 32'(ex_rs2), 17);

        // Hold three cycles with a dependent, changing ID instruction.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            hold = 1'b1;
            drive(1, 32'h300 + 32'(k * 4), 32'h7700 + 32'(k), 20 + 5'(k), 14, 14, 1, 1, 0, 1, 8'h66);
            #1;
            check($sformatf("hold%0d load_use_stall", k), 32'(load_use_stall), 0);
            @(posedge clk);
            #1;
            check($sformatf("hold%0d ex_pc", k), ex_pc, 32'h134);
            check($sformatf("hold%0d ex_rd", k), 32'(ex_rd), 14);
            check($sformatf("hold%0d ex_mem_read", k), 32'(ex_mem_read), 1);
            check($sformatf("hold%0d ex_ctrl", k), 32'(ex_ctrl), 32'h5A);
            check($sformatf("hold%0d stall_count", k), stall_count, 3);
        end

        // Release hold with an independent instruction: it loads at the next edge.
        @(negedge clk);
        hold = 1'b0;
        drive(1, 32'h200, 32'hE0, 15, 1, 2, 1, 1, 0, 1, 8'h77);
        #1;
        check("release load_use_stall", 32'(load_use_stall), 0);
        @(posedge clk);
        #1;
        check("release ex_pc", ex_pc, 32'h200);
        check("release ex_rd", 32'(ex_rd), 15);
        check("release ex_ctrl", 32'(ex_ctrl), 32'h77);

        // Reset during an active stall clears everything, including the stall.
        @(negedge clk);
        drive(1, 32'h204, 32'hF0, 16, 1, 0, 1, 0, 1, 1, 8'h11);
        @(posedge clk);
        @(negedge clk);
        drive(1, 32'h208, 32'h1, 18, 16, 0, 1, 0, 0, 1, 8'h22);
        #1;
        check("pre-reset load_use_stall", 32'(load_use_stall), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("mid-stall reset");

        @(negedge clk);
        rst = 1'b0;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
